// File: rtl/imm_ext_pipe.sv
// Immediate-field extractor/extender for decode, followed by a 2-entry
// valid/ready skid buffer with flush. Head entry drives the outputs directly.
module imm_ext_pipe #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned WORD_SHIFT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } entry_t;

  entry_t             head_q, head_d;
  entry_t             tail_q, tail_d;
  entry_t             new_entry;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  logic [DATA_W-1:0]  cb_sext, b_sext;
  logic               unused_instr_hi;

  // Instruction bits above the widest field are never consulted.
  assign unused_instr_hi = ^in_instr[INSTR_W-1:26];

  // Sign-extended branch offsets before the optional byte-offset shift.
  assign cb_sext = {{(DATA_W-19){in_instr[23]}}, in_instr[23:5]};
  assign b_sext  = {{(DATA_W-26){in_instr[25]}}, in_instr[25:0]};

  // Field select and extension for the entry being offered this cycle.
  always_comb begin
    new_entry     = '0;
    new_entry.tag = in_tag;
    case (in_mode)
      3'd0: new_entry.imm = DATA_W'(in_instr[21:10]);
      3'd1: new_entry.imm = {{(DATA_W-9){in_instr[20]}}, in_instr[20:12]};
      3'd2: new_entry.imm = (WORD_SHIFT != 0) ? (cb_sext << 2) : cb_sext;
      3'd3: new_entry.imm = (WORD_SHIFT != 0) ? (b_sext << 2) : b_sext;
      3'd4: new_entry.imm = DATA_W'(in_instr[20:5]) << {in_instr[22:21], 4'b0000};
      3'd5: new_entry.imm = DATA_W'(in_instr[15:10]);
      default: new_entry.err = 1'b1;
    endcase
  end

  // Handshake status depends only on occupancy.
  assign in_ready  = (count_q < CNT_W'(2));
  assign out_valid = (count_q != '0);
  assign out_imm   = head_q.imm;
  assign out_tag   = head_q.tag;
  assign out_err   = head_q.err;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next buffer state; empty slots are kept zeroed so idle outputs read 0.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Only reachable at count 1: new entry replaces the departing head.
          head_d = new_entry;
        end
        2'b10: begin
          if (count_q == '0) begin
            head_d  = new_entry;
            count_d = CNT_W'(1);
          end else begin
            tail_d  = new_entry;
            count_d = CNT_W'(2);
          end
        end
        2'b01: begin
          head_d  = tail_q;
          tail_d  = '0;
          count_d = count_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
